mem_map_bridge: RTL and testbench

- Parametrised successor to the fixed top-level address decode, which only had a 32K RAM window, a 4K text window and an 0xFF default.
- Sits between the CPU core and on-chip memories. Decodes up to three configurable regions (RAM, text/video, read-only BIOS) with per-region wait states.
- Registers every access and drives a ready/ce handshake so the core stalls on slow memories.
- Returns FILL for unmapped reads and drops writes to read-only regions.

---
 rtl/mem_map_bridge.sv | 184 ++++++++++++++++++
 tb/tb_mem_map_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_map_bridge.sv
// Address-decode bridge between the CPU core and up to three on-chip memory regions
// with per-region wait states. Optional sticky fault capture via MEM_MAP_BRIDGE_FAULT_EN.
module mem_map_bridge #(
  parameter int                 ADDR_W  = 20,
  parameter int                 DATA_W  = 8,
  parameter logic [ADDR_W-1:0]  R0_BASE = 20'h00000,
  parameter int                 R0_LOG2 = 15,
  parameter int                 R0_WAIT = 0,
  parameter logic [ADDR_W-1:0]  R1_BASE = 20'hB8000,
  parameter int                 R1_LOG2 = 12,
  parameter int                 R1_WAIT = 1,
  parameter logic [ADDR_W-1:0]  R2_BASE = 20'hFF000,
  parameter int                 R2_LOG2 = 12,
  parameter int                 R2_WAIT = 0,
  parameter logic [DATA_W-1:0]  FILL    = 8'hFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] in,
  output logic              ready,
  output logic              ce,
  output logic [ADDR_W-1:0] m_a,
  output logic [DATA_W-1:0] m_d,
  output logic [2:0]        m_sel,
  output logic [2:0]        m_w,
  input  logic [DATA_W-1:0] m_q0,
  input  logic [DATA_W-1:0] m_q1,
  input  logic [DATA_W-1:0] m_q2,
  output logic [1:0]        o_state
`ifdef MEM_MAP_BRIDGE_FAULT_EN
  ,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_clr
`endif
);

  // Handshake: the core holds req/we/address/out stable from request until ready;
  // ready is a one-cycle strobe in DONE, where req=1 starts the next access at once.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] MASK0 = ADDR_W'((64'd1 << R0_LOG2) - 64'd1);
  localparam logic [ADDR_W-1:0] MASK1 = ADDR_W'((64'd1 << R1_LOG2) - 64'd1);
  localparam logic [ADDR_W-1:0] MASK2 = ADDR_W'((64'd1 << R2_LOG2) - 64'd1);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic [2:0]        w_hit_raw;
  logic [2:0]        w_hit;
  logic [3:0]        w_wait;
  logic [ADDR_W-1:0] w_off;

  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_sel;
  logic [2:0]        r_w;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_in;

  // Region decode: compare the bits above each region's size against its base.
  always_comb begin
    w_hit_raw[0] = (address >> R0_LOG2) == (R0_BASE >> R0_LOG2);
    w_hit_raw[1] = (address >> R1_LOG2) == (R1_BASE >> R1_LOG2);
    w_hit_raw[2] = (address >> R2_LOG2) == (R2_BASE >> R2_LOG2);
    w_hit[0]     = w_hit_raw[0];
    w_hit[1]     = w_hit_raw[1] & ~w_hit_raw[0];
    w_hit[2]     = w_hit_raw[2] & ~w_hit_raw[1] & ~w_hit_raw[0];
  end

  always_comb begin
    w_wait = 4'd0;
    w_off  = address;
    if (w_hit[0]) begin
      w_wait = 4'(R0_WAIT);
      w_off  = address & MASK0;
    end else if (w_hit[1]) begin
      w_wait = 4'(R1_WAIT);
      w_off  = address & MASK1;
    end else if (w_hit[2]) begin
      w_wait = 4'(R2_WAIT);
      w_off  = address & MASK2;
    end
  end

  assign w_accept = req && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_state_next = S_DONE;
      S_DONE:   w_state_next = w_accept ? S_ACCESS : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Write strobe lives for the first ACCESS cycle only; R2 never gets one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= 4'd0;
      r_we  <= 1'b0;
      r_sel <= 3'b000;
      r_w   <= 3'b000;
      r_a   <= '0;
      r_d   <= '0;
      r_in  <= FILL;
    end else begin
      r_w <= 3'b000;
      if (w_accept) begin
        r_cnt <= w_wait;
        r_we  <= we;
        r_sel <= w_hit;
        r_w   <= we ? (w_hit & 3'b011) : 3'b000;
        r_a   <= w_off;
        r_d   <= out;
      end else if (r_state == S_ACCESS) begin
        if (r_cnt == 4'd0) begin
          r_sel <= 3'b000;
          if (!r_we) begin
            if (r_sel[0])      r_in <= m_q0;
            else if (r_sel[1]) r_in <= m_q1;
            else if (r_sel[2]) r_in <= m_q2;
            else               r_in <= FILL;
          end
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

`ifdef MEM_MAP_BRIDGE_FAULT_EN
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_addr;
  logic              w_new_fault;

  assign w_new_fault = w_accept && ((w_hit == 3'b000) || (we && w_hit[2]));

  // A clear on the same edge as a new fault re-arms capture, so the new fault is kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_new_fault && (!r_fault || fault_clr)) begin
      r_fault      <= 1'b1;
      r_fault_addr <= address;
    end else if (fault_clr) begin
      r_fault      <= 1'b0;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
`endif

  assign ready   = (r_state == S_DONE);
  assign ce      = (r_state == S_IDLE) || ready;
  assign in      = r_in;
  assign m_a     = r_a;
  assign m_d     = r_d;
  assign m_sel   = r_sel;
  assign m_w     = r_w;
  assign o_state = r_state;

endmodule

// File: tb/tb_mem_map_bridge.sv
// Self-checking bench for mem_map_bridge: directed scenarios plus randomized accesses
// checked against a region-arithmetic reference model.
module tb_mem_map_bridge;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [19:0] address = '0;
  logic [7:0]  cpu_wd = '0;
  logic [7:0]  cpu_rd;
  logic        ready;
  logic        ce;
  logic [19:0] m_a;
  logic [7:0]  m_d;
  logic [2:0]  m_sel;
  logic [2:0]  m_w;
  logic [7:0]  m_q0 = '0;
  logic [7:0]  m_q1 = '0;
  logic [7:0]  m_q2 = '0;
  logic [1:0]  o_state;
`ifdef MEM_MAP_BRIDGE_FAULT_EN
  logic        fault;
  logic [19:0] fault_addr;
  logic        fault_clr = 1'b0;
`endif

  mem_map_bridge dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .address(address),
    .out(cpu_wd), .in(cpu_rd), .ready(ready), .ce(ce), .m_a(m_a), .m_d(m_d),
    .m_sel(m_sel), .m_w(m_w), .m_q0(m_q0), .m_q1(m_q1), .m_q2(m_q2),
    .o_state(o_state)
`ifdef MEM_MAP_BRIDGE_FAULT_EN
    , .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference memory map
  int base_q[3] = '{'h00000, 'hB8000, 'hFF000};
  int log_q[3]  = '{15, 12, 12};
  int wait_q[3] = '{0, 1, 0};

  logic [7:0] exp_q[$];
  logic [7:0] cur_in;

  // Observations of the last transaction
  int         obs_lat;
  int         obs_sel_cyc;
  int         obs_w_cyc;
  logic [2:0] obs_sel_val;
  logic [2:0] obs_w_val;
  logic [19:0] obs_a;
  logic [7:0] obs_d;
  logic [7:0] obs_in;
  logic       obs_ce1;
  logic       obs_ce_rdy;
  logic [1:0] obs_state1;

  function automatic int region_of(input int a);
    for (int r = 0; r < 3; r++)
      if ((a / (1 << log_q[r])) == (base_q[r] / (1 << log_q[r]))) return r;
    return -1;
  endfunction

  // Presents one request at a negedge and watches until ready or the budget runs out.
  task automatic drive_txn(input logic [19:0] a, input logic wr, input logic [7:0] d,
                           input bit keep);
    int c;
    req = 1'b1; we = wr; address = a; cpu_wd = d;
    obs_lat = -1; obs_sel_cyc = 0; obs_w_cyc = 0; obs_sel_val = '0; obs_w_val = '0;
    c = 0;
    while (obs_lat < 0 && c < 40) begin
      @(negedge clock);
      c++;
      if (m_sel != 3'b000) begin obs_sel_cyc++; obs_sel_val = m_sel; end
      if (m_w != 3'b000) begin obs_w_cyc++; obs_w_val = m_w; end
      if (c == 1) begin obs_a = m_a; obs_d = m_d; obs_ce1 = ce; obs_state1 = o_state; end
      if (ready) begin obs_lat = c; obs_in = cpu_rd; obs_ce_rdy = ce; end
    end
    if (!keep) req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++; if (cpu_rd !== 8'hFF) begin n_err++; $display("FAIL reset_in got=%0h exp=ff", cpu_rd); end
    n_chk++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%0b exp=0", ready); end
    n_chk++; if (ce !== 1'b1) begin n_err++; $display("FAIL reset_ce got=%0b exp=1", ce); end
    n_chk++; if (m_sel !== 3'b000) begin n_err++; $display("FAIL reset_sel got=%0b exp=0", m_sel); end
    n_chk++; if (m_w !== 3'b000) begin n_err++; $display("FAIL reset_w got=%0b exp=0", m_w); end
    n_chk++; if (m_a !== 20'h0) begin n_err++; $display("FAIL reset_a got=%0h exp=0", m_a); end
    n_chk++; if (m_d !== 8'h0) begin n_err++; $display("FAIL reset_d got=%0h exp=0", m_d); end
    n_chk++; if (o_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", o_state, ST_IDLE); end
`ifdef MEM_MAP_BRIDGE_FAULT_EN
    n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    n_chk++; if (fault_addr !== 20'h0) begin n_err++; $display("FAIL reset_faddr got=%0h exp=0", fault_addr); end
`endif
    reset = 1'b0;
    cur_in = 8'hFF;
    @(negedge clock);
  endtask

  task automatic test_r0_read();
    m_q0 = 8'h5A; m_q1 = 8'h11; m_q2 = 8'h22;
    drive_txn(20'h00123, 1'b0, 8'h00, 1'b0);
    cur_in = 8'h5A;
    n_chk++; if (obs_lat !== 2) begin n_err++; $display("FAIL r0_lat got=%0d exp=2", obs_lat); end
    n_chk++; if (obs_in !== 8'h5A) begin n_err++; $display("FAIL r0_in got=%0h exp=5a", obs_in); end
    n_chk++; if (obs_sel_cyc !== 1) begin n_err++; $display("FAIL r0_sel_cyc got=%0d exp=1", obs_sel_cyc); end
    n_chk++; if (obs_sel_val !== 3'b001) begin n_err++; $display("FAIL r0_sel got=%0b exp=001", obs_sel_val); end
    n_chk++; if (obs_w_cyc !== 0) begin n_err++; $display("FAIL r0_w_cyc got=%0d exp=0", obs_w_cyc); end
    n_chk++; if (obs_a !== 20'h00123) begin n_err++; $display("FAIL r0_a got=%0h exp=123", obs_a); end
    n_chk++; if (obs_ce1 !== 1'b0) begin n_err++; $display("FAIL r0_ce_access got=%0b exp=0", obs_ce1); end
    n_chk++; if (obs_ce_rdy !== 1'b1) begin n_err++; $display("FAIL r0_ce_ready got=%0b exp=1", obs_ce_rdy); end
    @(negedge clock);
  endtask

  task automatic test_r1_write();
    drive_txn(20'hB8010, 1'b1, 8'h41, 1'b0);
    n_chk++; if (obs_lat !== 3) begin n_err++; $display("FAIL r1w_lat got=%0d exp=3", obs_lat); end
    n_chk++; if (obs_w_cyc !== 1) begin n_err++; $display("FAIL r1w_w_cyc got=%0d exp=1", obs_w_cyc); end
    n_chk++; if (obs_w_val !== 3'b010) begin n_err++; $display("FAIL r1w_w got=%0b exp=010", obs_w_val); end
    n_chk++; if (obs_sel_cyc !== 2) begin n_err++; $display("FAIL r1w_sel_cyc got=%0d exp=2", obs_sel_cyc); end
    n_chk++; if (obs_a !== 20'h00010) begin n_err++; $display("FAIL r1w_a got=%0h exp=10", obs_a); end
    n_chk++; if (obs_d !== 8'h41) begin n_err++; $display("FAIL r1w_d got=%0h exp=41", obs_d); end
    n_chk++; if (obs_in !== cur_in) begin n_err++; $display("FAIL r1w_in got=%0h exp=%0h", obs_in, cur_in); end
    @(negedge clock);
  endtask

  task automatic test_unmapped();
    drive_txn(20'h50000, 1'b0, 8'h00, 1'b0);
    cur_in = 8'hFF;
    n_chk++; if (obs_lat !== 2) begin n_err++; $display("FAIL unm_lat got=%0d exp=2", obs_lat); end
    n_chk++; if (obs_in !== 8'hFF) begin n_err++; $display("FAIL unm_in got=%0h exp=ff", obs_in); end
    n_chk++; if (obs_sel_cyc !== 0) begin n_err++; $display("FAIL unm_sel_cyc got=%0d exp=0", obs_sel_cyc); end
`ifdef MEM_MAP_BRIDGE_FAULT_EN
    n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL unm_fault got=%0b exp=1", fault); end
    n_chk++; if (fault_addr !== 20'h50000) begin n_err++; $display("FAIL unm_faddr got=%0h exp=50000", fault_addr); end
`endif
    @(negedge clock);
  endtask

  task automatic test_r2_write();
    drive_txn(20'hFF000, 1'b1, 8'h77, 1'b0);
    n_chk++; if (obs_lat !== 2) begin n_err++; $display("FAIL r2w_lat got=%0d exp=2", obs_lat); end
    n_chk++; if (obs_w_cyc !== 0) begin n_err++; $display("FAIL r2w_w_cyc got=%0d exp=0", obs_w_cyc); end
    n_chk++; if (obs_sel_val !== 3'b100) begin n_err++; $display("FAIL r2w_sel got=%0b exp=100", obs_sel_val); end
    n_chk++; if (obs_in !== cur_in) begin n_err++; $display("FAIL r2w_in got=%0h exp=%0h", obs_in, cur_in); end
`ifdef MEM_MAP_BRIDGE_FAULT_EN
    n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL r2w_fault got=%0b exp=1", fault); end
    n_chk++; if (fault_addr !== 20'h50000) begin n_err++; $display("FAIL r2w_first_only got=%0h exp=50000", fault_addr); end
    @(negedge clock);
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clr got=%0b exp=0", fault); end
    drive_txn(20'hFF004, 1'b1, 8'h78, 1'b0);
    n_chk++; if (fault_addr !== 20'hFF004) begin n_err++; $display("FAIL r2w_faddr got=%0h exp=ff004", fault_addr); end
`endif
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int lat1;
    m_q0 = 8'hC3;
    drive_txn(20'h00000, 1'b0, 8'h00, 1'b1);
    lat1 = obs_lat;
    n_chk++; if (obs_in !== 8'hC3) begin n_err++; $display("FAIL b2b_in0 got=%0h exp=c3", obs_in); end
    m_q0 = 8'h3C;
    drive_txn(20'h00001, 1'b0, 8'h00, 1'b0);
    cur_in = 8'h3C;
    n_chk++; if (lat1 !== 2) begin n_err++; $display("FAIL b2b_lat0 got=%0d exp=2", lat1); end
    n_chk++; if (obs_lat !== 2) begin n_err++; $display("FAIL b2b_lat1 got=%0d exp=2", obs_lat); end
    n_chk++; if (obs_state1 !== ST_ACCESS) begin n_err++; $display("FAIL b2b_no_idle got=%0d exp=%0d", obs_state1, ST_ACCESS); end
    n_chk++; if (obs_in !== 8'h3C) begin n_err++; $display("FAIL b2b_in1 got=%0h exp=3c", obs_in); end
    n_chk++; if (obs_a !== 20'h00001) begin n_err++; $display("FAIL b2b_a got=%0h exp=1", obs_a); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int seen;
    req = 1'b1; we = 1'b0; address = 20'hB8020;
    @(negedge clock);
    n_chk++; if (m_sel !== 3'b010) begin n_err++; $display("FAIL rmid_sel_pre got=%0b exp=010", m_sel); end
    reset = 1'b1; req = 1'b0;
    @(negedge clock);
    n_chk++; if (o_state !== ST_IDLE) begin n_err++; $display("FAIL rmid_state got=%0d exp=%0d", o_state, ST_IDLE); end
    n_chk++; if (m_sel !== 3'b000) begin n_err++; $display("FAIL rmid_sel got=%0b exp=0", m_sel); end
    n_chk++; if (ce !== 1'b1) begin n_err++; $display("FAIL rmid_ce got=%0b exp=1", ce); end
    reset = 1'b0;
    cur_in = 8'hFF;
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (ready) seen++;
    end
    n_chk++; if (seen !== 0) begin n_err++; $display("FAIL rmid_ready got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    logic [19:0] a;
    logic        wr;
    logic [7:0]  d;
    bit          keep;
    int          r;
    int          wt;
    logic [7:0]  mq[3];
    logic [7:0]  exp_in;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = 20'($urandom_range(0, 'h7FFF));
        1: a = 20'($urandom_range('hB8000, 'hB8FFF));
        2: a = 20'($urandom_range('hFF000, 'hFFFFF));
        3: a = 20'($urandom_range('h08000, 'hB7FFF));
        default: a = 20'($urandom_range('hC0000, 'hFEFFF));
      endcase
      wr = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      keep = (i != 39) && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 3; k++) mq[k] = 8'($urandom);
      m_q0 = mq[0]; m_q1 = mq[1]; m_q2 = mq[2];
      r = region_of(int'(a));
      wt = (r < 0) ? 0 : wait_q[r];
      if (!wr) cur_in = (r < 0) ? 8'hFF : mq[r];
      exp_q.push_back(cur_in);
      drive_txn(a, wr, d, keep);
      exp_in = exp_q.pop_front();
      n_chk++; if (obs_lat !== wt + 2) begin n_err++; $display("FAIL rnd_lat a=%0h got=%0d exp=%0d", a, obs_lat, wt + 2); end
      n_chk++; if (obs_in !== exp_in) begin n_err++; $display("FAIL rnd_in a=%0h got=%0h exp=%0h", a, obs_in, exp_in); end
      n_chk++; if (obs_sel_cyc !== ((r < 0) ? 0 : wt + 1)) begin n_err++; $display("FAIL rnd_sel_cyc a=%0h got=%0d", a, obs_sel_cyc); end
      n_chk++; if (obs_w_cyc !== ((wr && r >= 0 && r != 2) ? 1 : 0)) begin n_err++; $display("FAIL rnd_w_cyc a=%0h got=%0d", a, obs_w_cyc); end
      n_chk++; if (obs_d !== d) begin n_err++; $display("FAIL rnd_d a=%0h got=%0h exp=%0h", a, obs_d, d); end
      if (r >= 0) begin
        n_chk++; if (obs_a !== 20'(int'(a) % (1 << log_q[r]))) begin n_err++; $display("FAIL rnd_a a=%0h got=%0h", a, obs_a); end
        n_chk++; if (obs_sel_val !== 3'(1 << r)) begin n_err++; $display("FAIL rnd_sel a=%0h got=%0b", a, obs_sel_val); end
      end
      if (!keep) @(negedge clock);
    end
  endtask

  initial begin
    cur_in = 8'hFF;
    test_reset();
    test_r0_read();
    test_r1_write();
    test_unmapped();
    test_r2_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
